// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates N functional-unit results onto one registered common data bus
module cdb_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int REG_W    = 3,
  parameter int ARB_MODE = 0
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_CH-1:0]                         req_valid,
  input  logic [NUM_CH*DATA_W-1:0]                  req_data,
  input  logic [NUM_CH*TAG_W-1:0]                   req_tag,
  input  logic [NUM_CH*REG_W-1:0]                   req_dest,
  input  logic [NUM_CH-1:0]                         req_wr,
  output logic [NUM_CH-1:0]                         req_ready,
  output logic                                      cdb_valid,
  output logic [DATA_W-1:0]                         cdb_data,
  output logic [TAG_W-1:0]                          cdb_tag,
  output logic [REG_W-1:0]                          cdb_dest,
  output logic                                      cdb_wr_en,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cdb_ch
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic [CH_W-1:0]   rrPtr, grantIdx, nextPtr;
  logic [NUM_CH-1:0] grantVec;
  logic              found;
  logic [DATA_W-1:0] selData;
  logic [TAG_W-1:0]  selTag;
  logic [REG_W-1:0]  selDest;
  logic              selWr;
  int                startIdx;
  // Two-pass search: channels at/after the start index first, then the wrapped ones; winner's fields are muxed out
  always_comb begin
    startIdx = (ARB_MODE != 0) ? 0 : int'(rrPtr);
    found    = 1'b0;
    grantIdx = '0;
    nextPtr  = rrPtr;
    grantVec = '0;
    selData  = '0;
    selTag   = '0;
    selDest  = '0;
    selWr    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req_valid[i] && ((p == 0) ? (i >= startIdx) : (i < startIdx))) begin
          found       = 1'b1;
          grantIdx    = CH_W'(i);
          nextPtr     = (i == NUM_CH - 1) ? '0 : CH_W'(i + 1);
          grantVec[i] = 1'b1;
          selData     = req_data[i*DATA_W +: DATA_W];
          selTag      = req_tag[i*TAG_W +: TAG_W];
          selDest     = req_dest[i*REG_W +: REG_W];
          selWr       = req_wr[i];
        end
      end
    end
    req_ready = reset ? '0 : grantVec;
  end
  // Register the granted result for a one-cycle broadcast; payload holds when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr     <= '0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_dest  <= '0;
      cdb_wr_en <= 1'b0;
      cdb_ch    <= '0;
    end else begin
      cdb_valid <= found;
      cdb_wr_en <= found && selWr && (selDest != '0);
      if (found) begin
        rrPtr    <= nextPtr;
        cdb_data <= selData;
        cdb_tag  <= selTag;
        cdb_dest <= selDest;
        cdb_ch   <= grantIdx;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter in round-robin and fixed-priority modes
module tb_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  reqValid;
  logic [63:0] reqData;
  logic [11:0] reqTag, reqDest;
  logic [3:0]  reqWr;
  logic [3:0]  rrReady, fpReady;
  logic        rrValid, fpValid, rrWrEn, fpWrEn;
  logic [15:0] rrData, fpData;
  logic [2:0]  rrTag, fpTag, rrDest, fpDest;
  logic [1:0]  rrCh, fpCh;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.ARB_MODE(0)) dutRr (
    .clock(clock), .reset(reset), .req_valid(reqValid), .req_data(reqData), .req_tag(reqTag),
    .req_dest(reqDest), .req_wr(reqWr), .req_ready(rrReady), .cdb_valid(rrValid), .cdb_data(rrData),
    .cdb_tag(rrTag), .cdb_dest(rrDest), .cdb_wr_en(rrWrEn), .cdb_ch(rrCh)
  );

  cdb_arbiter #(.ARB_MODE(1)) dutFp (
    .clock(clock), .reset(reset), .req_valid(reqValid), .req_data(reqData), .req_tag(reqTag),
    .req_dest(reqDest), .req_wr(reqWr), .req_ready(fpReady), .cdb_valid(fpValid), .cdb_data(fpData),
    .cdb_tag(fpTag), .cdb_dest(fpDest), .cdb_wr_en(fpWrEn), .cdb_ch(fpCh)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setCh(input int c, input logic v, input logic [15:0] d, input logic [2:0] t,
                       input logic [2:0] r, input logic w);
    reqValid[c]          = v;
    reqData[c*16 +: 16]  = d;
    reqTag[c*3 +: 3]     = t;
    reqDest[c*3 +: 3]    = r;
    reqWr[c]             = w;
  endtask

  task automatic doReset();
    reqValid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reqValid = '0; reqData = '0; reqTag = '0; reqDest = '0; reqWr = '0;
    doReset();
    vectors++;
    if ({rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", {rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh});
    end
    vectors++;
    if (rrReady !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready got=%b exp=0000", rrReady);
    end
  endtask

  task automatic test_single();
    setCh(2, 1'b1, 16'h1234, 3'd3, 3'd5, 1'b1);
    #1;
    vectors++;
    if (rrReady !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_ready got=%b exp=0100", rrReady);
    end
    tick();
    reqValid[2] = 1'b0;
    vectors++;
    if ({rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh} !== {1'b1, 16'h1234, 3'd3, 3'd5, 1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL single_bcast got=%h exp=%h", {rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh},
               {1'b1, 16'h1234, 3'd3, 3'd5, 1'b1, 2'd2});
    end
    tick();
    vectors++;
    if (rrValid !== 1'b0 || rrData !== 16'h1234) begin
      miscompares++;
      $display("FAIL single_idle got valid=%b data=%h exp valid=0 data=1234", rrValid, rrData);
    end
  endtask

  task automatic test_round_robin();
    int exp [5] = '{0, 1, 2, 3, 0};
    doReset();
    for (int c = 0; c < 4; c++) setCh(c, 1'b1, 16'hA000 + 16'(c), 3'(c + 1), 3'(c + 2), 1'b1);
    #1;
    for (int n = 0; n < 5; n++) begin
      vectors++;
      if (rrReady !== 4'(1 << exp[n])) begin
        miscompares++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", n, rrReady, 4'(1 << exp[n]));
      end
      tick();
      vectors++;
      if (rrValid !== 1'b1 || rrCh !== 2'(exp[n]) || rrData !== 16'hA000 + 16'(exp[n])) begin
        miscompares++;
        $display("FAIL rr_bcast[%0d] got valid=%b ch=%0d data=%h exp valid=1 ch=%0d data=%h",
                 n, rrValid, rrCh, rrData, exp[n], 16'hA000 + 16'(exp[n]));
      end
    end
    reqValid = '0;
    tick();
  endtask

  task automatic test_rr_skip();
    doReset();
    setCh(3, 1'b1, 16'h0033, 3'd1, 3'd1, 1'b1);
    tick();
    reqValid = '0;
    setCh(1, 1'b1, 16'h0011, 3'd2, 3'd2, 1'b1);
    setCh(3, 1'b1, 16'h0333, 3'd4, 3'd3, 1'b1);
    #1;
    vectors++;
    if (rrReady !== 4'b0010) begin
      miscompares++;
      $display("FAIL skip_ready1 got=%b exp=0010", rrReady);
    end
    tick();
    reqValid[1] = 1'b0;
    vectors++;
    if (rrCh !== 2'd1 || rrData !== 16'h0011) begin
      miscompares++;
      $display("FAIL skip_bcast1 got ch=%0d data=%h exp ch=1 data=0011", rrCh, rrData);
    end
    vectors++;
    if (rrReady !== 4'b1000) begin
      miscompares++;
      $display("FAIL skip_ready2 got=%b exp=1000", rrReady);
    end
    tick();
    reqValid = '0;
    vectors++;
    if (rrValid !== 1'b1 || rrCh !== 2'd3 || rrData !== 16'h0333) begin
      miscompares++;
      $display("FAIL skip_bcast2 got valid=%b ch=%0d data=%h exp valid=1 ch=3 data=0333", rrValid, rrCh, rrData);
    end
    tick();
  endtask

  task automatic test_fixed_priority();
    doReset();
    setCh(0, 1'b1, 16'h0100, 3'd1, 3'd1, 1'b1);
    setCh(2, 1'b1, 16'h0200, 3'd2, 3'd2, 1'b1);
    #1;
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (fpReady !== 4'b0001) begin
        miscompares++;
        $display("FAIL fp_ready[%0d] got=%b exp=0001", n, fpReady);
      end
      tick();
      vectors++;
      if (fpValid !== 1'b1 || fpCh !== 2'd0 || fpData !== 16'h0100 + 16'(n)) begin
        miscompares++;
        $display("FAIL fp_bcast[%0d] got valid=%b ch=%0d data=%h exp valid=1 ch=0 data=%h",
                 n, fpValid, fpCh, fpData, 16'h0100 + 16'(n));
      end
      setCh(0, 1'b1, 16'h0101 + 16'(n), 3'd1, 3'd1, 1'b1);
    end
    reqValid[0] = 1'b0;
    #1;
    vectors++;
    if (fpReady !== 4'b0100) begin
      miscompares++;
      $display("FAIL fp_ready_ch2 got=%b exp=0100", fpReady);
    end
    tick();
    reqValid = '0;
    vectors++;
    if (fpValid !== 1'b1 || fpCh !== 2'd2 || fpData !== 16'h0200) begin
      miscompares++;
      $display("FAIL fp_bcast_ch2 got valid=%b ch=%0d data=%h exp valid=1 ch=2 data=0200", fpValid, fpCh, fpData);
    end
    tick();
  endtask

  task automatic test_write_enable();
    doReset();
    setCh(1, 1'b1, 16'hBEEF, 3'd6, 3'd0, 1'b1);
    tick();
    reqValid = '0;
    vectors++;
    if (rrValid !== 1'b1 || rrWrEn !== 1'b0 || rrDest !== 3'd0) begin
      miscompares++;
      $display("FAIL wr_dest0 got valid=%b wr_en=%b dest=%0d exp valid=1 wr_en=0 dest=0", rrValid, rrWrEn, rrDest);
    end
    tick();
    setCh(1, 1'b1, 16'hCAFE, 3'd7, 3'd4, 1'b0);
    tick();
    reqValid = '0;
    vectors++;
    if (rrValid !== 1'b1 || rrWrEn !== 1'b0 || rrDest !== 3'd4) begin
      miscompares++;
      $display("FAIL wr_nowrite got valid=%b wr_en=%b dest=%0d exp valid=1 wr_en=0 dest=4", rrValid, rrWrEn, rrDest);
    end
    tick();
  endtask

  task automatic test_reset_mid_broadcast();
    doReset();
    setCh(1, 1'b1, 16'h5555, 3'd5, 3'd6, 1'b1);
    tick();
    reqValid = '0;
    setCh(0, 1'b1, 16'h7777, 3'd2, 3'd3, 1'b1);
    reset = 1'b1;
    #1;
    vectors++;
    if (rrReady !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_ready got=%b exp=0000", rrReady);
    end
    tick();
    vectors++;
    if ({rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh} !== 26'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs got=%h exp=0", {rrValid, rrData, rrTag, rrDest, rrWrEn, rrCh});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (rrReady !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_regrant got=%b exp=0001", rrReady);
    end
    tick();
    reqValid = '0;
    vectors++;
    if (rrValid !== 1'b1 || rrCh !== 2'd0 || rrData !== 16'h7777) begin
      miscompares++;
      $display("FAIL midrst_bcast got valid=%b ch=%0d data=%h exp valid=1 ch=0 data=7777", rrValid, rrCh, rrData);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_fixed_priority();
    test_write_enable();
    test_reset_mid_broadcast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
